// File: rtl/ahb_bram_pkg.sv
// rtl/ahb_bram_pkg.sv - shared AHB-Lite codes and response FSM encoding for the BRAM controller
package ahb_bram_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } resp_state_t;

endpackage

// File: rtl/bram_byte_lane_dec.sv
// rtl/bram_byte_lane_dec.sv - byte-lane mask and size/alignment check for one AHB transfer
module bram_byte_lane_dec
   import ahb_bram_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr_lo,
   output logic [3:0] mask,
   output logic       size_err
);

   always_comb begin
      mask     = 4'b0000;
      size_err = 1'b0;
      case (hsize)
         HSIZE_BYTE: mask = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
            size_err = addr_lo[0];
         end
         HSIZE_WORD: begin
            mask     = 4'b1111;
            size_err = |addr_lo;
         end
         default: size_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// rtl/ahb_bram_ctrl.sv - zero-wait AHB-Lite slave for a byte-write, registered-read block RAM
// Writes commit one cycle late, so a read hitting the pending write word is patched by forwarding.
module ahb_bram_ctrl
   import ahb_bram_pkg::*;
#(
   parameter int ADDR_WIDTH  = 14,
   parameter int WINDOW_BITS = 28
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [3:0]            HPROT,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
   output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
   output logic [31:0]           BRAM_WDATA,
   output logic [3:0]            BRAM_WE,
   input  logic [31:0]           BRAM_RDATA
);

   resp_state_t           state_q, state_d;
   logic                  wr_pend;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            mask_q;
   logic [ADDR_WIDTH-1:0] rdaddr_q;
   logic                  fwd_en;
   logic [3:0]            fwd_mask;
   logic [31:0]           fwd_data;

   logic [3:0]            lane_mask;
   logic                  size_err;
   logic                  range_err;
   logic                  xfer_valid;
   logic                  xfer_ok;
   logic                  xfer_bad;
   logic                  fwd_hit;
   logic [ADDR_WIDTH-1:0] haddr_word;
   logic                  hreadyout_d;
   logic                  hresp_d;
   logic                  unused_bits;

   assign unused_bits = ^{HPROT, HADDR[31:WINDOW_BITS]};

   bram_byte_lane_dec u_lane_dec (
      .hsize    (HSIZE),
      .addr_lo  (HADDR[1:0]),
      .mask     (lane_mask),
      .size_err (size_err)
   );

   assign haddr_word = HADDR[ADDR_WIDTH+1:2];
   assign range_err  = |HADDR[WINDOW_BITS-1:ADDR_WIDTH+2];
   assign xfer_valid = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign xfer_ok    = xfer_valid && !size_err && !range_err;
   assign xfer_bad   = xfer_valid && (size_err || range_err);
   assign fwd_hit    = xfer_ok && !HWRITE && wr_pend && (addr_q == haddr_word);

   // Hold the read address through other slaves' wait states so BRAM_RDATA stays put.
   assign BRAM_RDADDR = HREADY ? haddr_word : rdaddr_q;
   assign BRAM_WRADDR = addr_q;
   assign BRAM_WDATA  = HWDATA;
   // Gating with HRESETn drops a write whose data phase coincides with a reset edge.
   assign BRAM_WE     = (wr_pend && HRESETn) ? mask_q : 4'b0000;

   always_comb begin
      HRDATA = BRAM_RDATA;
      for (int i = 0; i < 4; i++) begin
         if (fwd_en && fwd_mask[i]) begin
            HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      hreadyout_d = 1'b1;
      hresp_d     = 1'b0;
      case (state_q)
         ST_OK: begin
            if (xfer_bad) state_d = ST_ERR1;
         end
         ST_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
            state_d     = ST_ERR2;
         end
         ST_ERR2: begin
            hresp_d = 1'b1;
            state_d = xfer_bad ? ST_ERR1 : ST_OK;
         end
         default: state_d = ST_OK;
      endcase
   end

   assign HREADYOUT = hreadyout_d;
   assign HRESP     = hresp_d;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q  <= ST_OK;
         wr_pend  <= 1'b0;
         addr_q   <= '0;
         mask_q   <= 4'b0000;
         rdaddr_q <= '0;
         fwd_en   <= 1'b0;
         fwd_mask <= 4'b0000;
         fwd_data <= 32'h0;
      end else begin
         state_q  <= state_d;
         rdaddr_q <= BRAM_RDADDR;
         if (HREADY) begin
            wr_pend <= xfer_ok && HWRITE;
            if (xfer_ok) begin
               addr_q <= haddr_word;
               mask_q <= lane_mask;
            end
         end
         fwd_en <= fwd_hit;
         if (fwd_hit) begin
            fwd_mask <= mask_q;
            fwd_data <= HWDATA;
         end
      end
   end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb/tb_ahb_bram_ctrl.sv - scoreboard bench for ahb_bram_ctrl with a behavioural block RAM
module tb_ahb_bram_ctrl;

   localparam int AW = 14;
   localparam int P_IDLE = 0, P_RD = 1, P_WR = 2, P_ERR1 = 3, P_ERR2 = 4;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [3:0]    HPROT;
   logic          HWRITE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic [AW-1:0] BRAM_RDADDR;
   logic [AW-1:0] BRAM_WRADDR;
   logic [31:0]   BRAM_WDATA;
   logic [3:0]    BRAM_WE;
   logic [31:0]   BRAM_RDATA;
   logic          other_rdy;

   logic [31:0]   bram    [0:(1<<AW)-1];
   logic [31:0]   ref_mem [0:(1<<AW)-1];
   logic [31:0]   exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            prev;
   logic [3:0]    exp_we;
   logic [AW-1:0] exp_waddr;
   logic [31:0]   dp_wdata;
   logic [31:0]   old_word;

   always #5 HCLK = ~HCLK;

   assign HREADY = HREADYOUT & other_rdy;

   ahb_bram_ctrl #(.ADDR_WIDTH(AW), .WINDOW_BITS(28)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HSEL        (HSEL),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSIZE       (HSIZE),
      .HPROT       (HPROT),
      .HWRITE      (HWRITE),
      .HWDATA      (HWDATA),
      .HREADY      (HREADY),
      .HREADYOUT   (HREADYOUT),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .BRAM_RDADDR (BRAM_RDADDR),
      .BRAM_WRADDR (BRAM_WRADDR),
      .BRAM_WDATA  (BRAM_WDATA),
      .BRAM_WE     (BRAM_WE),
      .BRAM_RDATA  (BRAM_RDATA)
   );

   // Read-before-write RAM: a same-edge read of the written word returns the old data.
   always @(posedge HCLK) begin
      for (int i = 0; i < 4; i++) begin
         if (BRAM_WE[i]) bram[BRAM_WRADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
      end
      BRAM_RDATA <= bram[BRAM_RDADDR];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_mask(input logic [2:0] s, input logic [1:0] lo);
      case (s)
         3'd0:    return 4'b0001 << lo;
         3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_bad(input logic [2:0] s, input logic [31:0] a);
      return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00)
             || (a[27:16] != 12'h0);
   endfunction

   // Drive one address phase, check the data phase of the previous one, update the model.
   task automatic step(input logic [1:0] trans, input logic [31:0] addr, input logic [2:0] size,
                       input logic wr, input logic [31:0] wd);
      logic [3:0]  m;
      logic [31:0] e;
      logic        acc;
      HSEL   = 1'b1;
      HTRANS = trans;
      HADDR  = addr;
      HSIZE  = size;
      HWRITE = wr;
      HWDATA = dp_wdata;
      @(negedge HCLK);
      case (prev)
         P_RD: begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            chk("rd_data", HRDATA, e);
            chk("rd_rdy", {31'h0, HREADYOUT}, 32'h1);
            chk("rd_resp", {31'h0, HRESP}, 32'h0);
         end
         P_WR: begin
            chk("wr_we", {28'h0, BRAM_WE}, {28'h0, exp_we});
            chk("wr_addr", {18'h0, BRAM_WRADDR}, {18'h0, exp_waddr});
            chk("wr_data", BRAM_WDATA, dp_wdata);
            chk("wr_resp", {31'h0, HRESP}, 32'h0);
         end
         P_ERR1: begin
            chk("err1_rdy", {31'h0, HREADYOUT}, 32'h0);
            chk("err1_resp", {31'h0, HRESP}, 32'h1);
            chk("err1_we", {28'h0, BRAM_WE}, 32'h0);
         end
         P_ERR2: begin
            chk("err2_rdy", {31'h0, HREADYOUT}, 32'h1);
            chk("err2_resp", {31'h0, HRESP}, 32'h1);
            chk("err2_we", {28'h0, BRAM_WE}, 32'h0);
         end
         default: begin
            chk("idle_rdy", {31'h0, HREADYOUT}, 32'h1);
            chk("idle_resp", {31'h0, HRESP}, 32'h0);
            chk("idle_we", {28'h0, BRAM_WE}, 32'h0);
         end
      endcase
      acc = trans[1] && (prev != P_ERR1);
      m   = exp_mask(size, addr[1:0]);
      if (prev == P_ERR1) begin
         prev = P_ERR2;
      end else if (!acc) begin
         prev = P_IDLE;
      end else if (is_bad(size, addr)) begin
         prev = P_ERR1;
      end else if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (m[i]) ref_mem[addr[15:2]][8*i +: 8] = wd[8*i +: 8];
         end
         exp_we    = m;
         exp_waddr = addr[15:2];
         dp_wdata  = wd;
         prev      = P_WR;
      end else begin
         exp_q.push_back(ref_mem[addr[15:2]]);
         prev = P_RD;
      end
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle();
      step(2'd0, 32'h0, 3'd2, 1'b0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      HRESETn   = 1'b0;
      HSEL      = 1'b0;
      HADDR     = 32'h0;
      HTRANS    = 2'd0;
      HSIZE     = 3'd0;
      HPROT     = 4'h3;
      HWRITE    = 1'b0;
      HWDATA    = 32'h0;
      other_rdy = 1'b1;
      prev      = P_IDLE;
      exp_we    = 4'h0;
      exp_waddr = '0;
      dp_wdata  = 32'h0;
      repeat (2) @(posedge HCLK);
      #1;
      @(negedge HCLK);
      chk("rst_rdy", {31'h0, HREADYOUT}, 32'h1);
      chk("rst_resp", {31'h0, HRESP}, 32'h0);
      chk("rst_we", {28'h0, BRAM_WE}, 32'h0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      // word write then read back
      step(2'd2, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
      idle();
      step(2'd2, 32'h10, 3'd2, 1'b0, 32'h0);
      idle();

      // byte write followed immediately by a read of the same word (forwarded)
      step(2'd2, 32'h10, 3'd2, 1'b1, 32'h11223344);
      step(2'd3, 32'h13, 3'd0, 1'b1, 32'hAA000000);
      step(2'd2, 32'h10, 3'd2, 1'b0, 32'h0);
      idle();

      // halfword write to the upper half, then read
      step(2'd2, 32'h20, 3'd2, 1'b1, 32'h99887766);
      step(2'd2, 32'h22, 3'd1, 1'b1, 32'h55660000);
      idle();
      step(2'd2, 32'h20, 3'd2, 1'b0, 32'h0);
      idle();

      // BUSY must not write
      step(2'd1, 32'h20, 3'd2, 1'b1, 32'h0);
      idle();

      // misaligned word write: two-cycle error, memory untouched
      step(2'd2, 32'h0, 3'd2, 1'b1, 32'hCAFEF00D);
      idle();
      step(2'd2, 32'h2, 3'd2, 1'b1, 32'h12345678);
      dp_wdata = 32'h12345678;
      idle();
      idle();
      step(2'd2, 32'h0, 3'd2, 1'b0, 32'h0);
      idle();

      // out-of-range read; legal read accepted during ERR2 completes with OKAY
      step(2'd2, 32'h0001_0000, 3'd2, 1'b0, 32'h0);
      idle();
      step(2'd2, 32'h10, 3'd2, 1'b0, 32'h0);
      idle();

      // illegal size, then a second illegal transfer accepted in ERR2
      step(2'd2, 32'h0, 3'd3, 1'b0, 32'h0);
      idle();
      step(2'd2, 32'h1, 3'd1, 1'b1, 32'h0);
      idle();
      idle();
      idle();

      // read address is held while another slave stalls the bus
      step(2'd0, 32'h44, 3'd2, 1'b0, 32'h0);
      other_rdy = 1'b0;
      HADDR     = 32'h80;
      HTRANS    = 2'd2;
      #1;
      chk("rdaddr_hold", {18'h0, BRAM_RDADDR}, 32'h11);
      other_rdy = 1'b1;
      #1;
      chk("rdaddr_live", {18'h0, BRAM_RDADDR}, 32'h20);
      HTRANS = 2'd0;
      idle();

      // reset during a write data phase discards the write
      step(2'd2, 32'h30, 3'd2, 1'b1, 32'h0BADC0DE);
      idle();
      old_word = ref_mem[12];
      step(2'd2, 32'h30, 3'd2, 1'b1, 32'hFFFFFFFF);
      ref_mem[12] = old_word;
      HRESETn = 1'b0;
      HTRANS  = 2'd0;
      HWDATA  = dp_wdata;
      @(negedge HCLK);
      chk("rst_wr_we", {28'h0, BRAM_WE}, 32'h0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      prev    = P_IDLE;
      idle();
      step(2'd2, 32'h30, 3'd2, 1'b0, 32'h0);
      idle();

      if (exp_q.size() != 0) chk("sb_left", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave controller that sequences the SoC's single-clock block RAM, which has a byte-write port and a registered read port.
- Translates Cortex-M0 bus transfers into RAM read addresses, write addresses and byte enables.
- Resolves the same-cycle read/write hazard.
- Generates AHB ERROR responses for illegal accesses.
- Sits between the AHB decoder/mux and the RAM; zero wait states for all legal transfers.

Parameters:
ADDR_WIDTH, 14, RAM word-address width (RAM = 2**ADDR_WIDTH x 32 bit)
WINDOW_BITS, 28, byte-address bits decoded inside this slave's HSEL region

Ports:
HCLK  input  1  system clock, all logic on rising edge
HRESETn  input  1  reset, synchronous, active-low
HSEL  input  1  slave select
HADDR  input  32  transfer byte address
HTRANS  input  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HSIZE  input  3  transfer size
HPROT  input  4  protection, ignored
HWRITE  input  1  1 = write
HWDATA  input  32  write data, data phase
HREADY  input  1  bus-wide ready
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  32  read data
BRAM_RDADDR  output  ADDR_WIDTH  RAM read word address
BRAM_WRADDR  output  ADDR_WIDTH  RAM write word address
BRAM_WDATA  output  32  RAM write data
BRAM_WE  output  4  RAM byte write enables
BRAM_RDATA  input  32  RAM registered read data (1-cycle latency)

Behaviour:
- Valid transfer: HSEL & HREADY & HTRANS[1]. IDLE/BUSY get an OKAY, zero-wait response with no RAM write.
- Illegal transfer conditions:
  - HSIZE > 2.
  - Misaligned address: halfword with HADDR[0]=1, or word with HADDR[1:0] != 0.
  - Out of range: HADDR[WINDOW_BITS-1:ADDR_WIDTH+2] != 0.
- Byte mask:
  - size 0: one-hot on HADDR[1:0].
  - size 1: 0011 or 1100 selected by HADDR[1].
  - size 2: 1111.
- Address phase, on a legal valid transfer, register:
  - wr_pend = HWRITE
  - addr_q = HADDR[ADDR_WIDTH+1:2]
  - mask_q = byte mask
- BRAM_RDADDR = HADDR word address when HREADY=1, else rdaddr_q (the last value driven). This keeps BRAM_RDATA stable across other slaves' wait states.
- Write data phase (cycle after the address phase):
  - BRAM_WE = mask_q when wr_pend, else 0000.
  - BRAM_WRADDR = addr_q; BRAM_WDATA = HWDATA.
  - The RAM commits at the edge ending the data phase.
- Read latency: address phase in cycle N gives HRDATA valid in cycle N+1 with HREADYOUT=1.
- Hazard (read address phase to word A coinciding with a write data phase to A): the RAM returns old data.
  - At that edge, capture fwd_en=1, fwd_mask=mask_q, fwd_data=HWDATA.
  - In the next cycle HRDATA lane i = fwd_mask[i] ? fwd_data lane i : BRAM_RDATA lane i.
  - fwd_en clears after one cycle. No forwarding if the addresses differ or the write was errored.
- FSM states:
  - OK: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - OK -> ERR1 on an illegal valid transfer.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if another illegal transfer is accepted (HREADY=1) in ERR2.
  - ERR2 -> OK otherwise.
- An errored transfer never asserts BRAM_WE and never sets wr_pend. A legal transfer accepted during ERR2 proceeds normally.
- Reset (synchronous, HRESETn low at the edge):
  - State = OK, HREADYOUT=1, HRESP=0, BRAM_WE=0000.
  - wr_pend, fwd_en, mask_q, addr_q, rdaddr_q, fwd_data all cleared.
  - A write pending in its data phase is discarded.
- Address wrap: none. Out-of-range addresses error rather than alias.

Decomposition:
- Package ahb_bram_pkg holds:
  - HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - HSIZE codes (BYTE=0, HALF=1, WORD=2).
  - FSM encodings OK/ERR1/ERR2.
- One combinational sub-module, bram_byte_lane_dec: inputs HSIZE and HADDR[1:0]; outputs the 4-bit mask and a misalign/size-error flag.

Test Plan:
1. Reset released, then word write 0x0000_0010 = 0xDEADBEEF, idle, read 0x10 -> write cycle has BRAM_WE=1111, BRAM_WRADDR=4; read returns HRDATA=0xDEADBEEF one cycle after its address phase, HRESP=0.
2. Byte write 0xAA to 0x13, then back-to-back read of 0x10 (read address phase in the write data phase), RAM word initially 0x11223344 -> BRAM_WE=1000; HRDATA=0xAA223344 via forwarding.
3. Halfword write 0x5566 to 0x22, then read 0x20 -> BRAM_WE=1100; HRDATA[31:16]=0x5566, lower half unchanged.
4. Word write to 0x0000_0002 (misaligned) -> ERR1 cycle (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); BRAM_WE stays 0000; a following read of 0x0 shows the old data.
5. Read 0x0001_0000 with ADDR_WIDTH=14 (out of range) -> two-cycle ERROR; next legal read gets OKAY and zero wait.
6. HRESETn low for one edge during a write data phase to 0x30 -> BRAM_WE=0000 after the edge; later read of 0x30 returns the pre-write value.
